// File: rtl/csr_state_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_state_unit_pkg: shared cause codes and CSR state bundles       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package csr_state_unit_pkg;

  typedef enum logic [31:0] {
    MCAUSE_INSTR_MISALIGN = 32'h0000_0000,
    MCAUSE_INSTR_FAULT    = 32'h0000_0001,
    MCAUSE_ILLEGAL_INSTR  = 32'h0000_0002,
    MCAUSE_BREAKPOINT     = 32'h0000_0003,
    MCAUSE_LOAD_MISALIGN  = 32'h0000_0004,
    MCAUSE_LOAD_FAULT     = 32'h0000_0005,
    MCAUSE_STORE_MISALIGN = 32'h0000_0006,
    MCAUSE_STORE_FAULT    = 32'h0000_0007,
    MCAUSE_ECALL_M        = 32'h0000_000B,
    MCAUSE_IRQ_MSI        = 32'h8000_0003,
    MCAUSE_IRQ_MTI        = 32'h8000_0007,
    MCAUSE_IRQ_MEI        = 32'h8000_000B
  } mcause_t;

  typedef struct packed {
    logic        mie;
    logic        mpie;
    logic        mtie;
    logic        msie;
    logic        meie;
    logic [29:0] mtvec_base;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        mcycle_inhibit;
    logic        minstret_inhibit;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } csr_state_t;

  // Everything except the two 64-bit counters, which live in their own sub-modules
  typedef struct packed {
    logic        mie;
    logic        mpie;
    logic        mtie;
    logic        msie;
    logic        meie;
    logic [29:0] mtvec_base;
    logic        mcycle_inhibit;
    logic        minstret_inhibit;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } csr_core_t;

  localparam logic [31:0] c_PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic csr_core_t core_of(input csr_state_t s);
    csr_core_t c;
    c.mie              = s.mie;
    c.mpie             = s.mpie;
    c.mtie             = s.mtie;
    c.msie             = s.msie;
    c.meie             = s.meie;
    c.mtvec_base       = s.mtvec_base;
    c.mcycle_inhibit   = s.mcycle_inhibit;
    c.minstret_inhibit = s.minstret_inhibit;
    c.mscratch         = s.mscratch;
    c.mepc             = s.mepc;
    c.mcause           = s.mcause;
    c.mtval            = s.mtval;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_state_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_state_unit_if: core/decoder side bundle of the CSR state unit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface csr_state_unit_if;
  import csr_state_unit_pkg::*;

  logic        csr_we;
  csr_state_t  csr_next;
  csr_state_t  csr_state;
  logic        mtip;
  logic        msip;
  logic        meip;
  logic        instr_retire;
  logic        exc_valid;
  mcause_t     exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic        irq_pending;
  logic        irq_take;
  logic [31:0] irq_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output csr_we, csr_next, mtip, msip, meip, instr_retire,
           exc_valid, exc_cause, exc_pc, exc_tval, mret, irq_take, irq_pc,
    input  csr_state, irq_pending, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_we, csr_next, mtip, msip, meip, instr_retire,
           exc_valid, exc_cause, exc_pc, exc_tval, mret, irq_take, irq_pc,
    output csr_state, irq_pending, redirect_valid, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/csr_state_unit_counter64.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter64: 64-bit wrapping counter where a write beats an increment|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter64 (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        en_i,
  input  wire logic        we_i,
  input  wire logic [63:0] wd_i,
  output logic      [63:0] q_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      cnt_d = wd_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_state_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_state_unit: machine-mode CSR state, trap entry, mret, counters |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module csr_state_unit
  import csr_state_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input wire logic          clk,
  input wire logic          rst_n,
  csr_state_unit_if.slave   bus
);

  localparam csr_core_t c_CORE_RST = '{mtvec_base: RESET_MTVEC[31:2], default: '0};

  csr_core_t   core_q;
  csr_core_t   core_d;
  logic        redirect_valid_q;
  logic        redirect_valid_d;
  logic [31:0] redirect_pc_q;
  logic [31:0] redirect_pc_d;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic        w_irq_pending;
  logic        w_exc;
  logic        w_irq;
  logic        w_mret;
  logic        w_csr;
  logic        w_trap;
  mcause_t     w_irq_cause;

  assign w_irq_pending = core_q.mie & ((bus.meip & core_q.meie) |
                                       (bus.msip & core_q.msie) |
                                       (bus.mtip & core_q.mtie));

  // Exactly one event commits per cycle; an irq_take with nothing pending is not an event
  assign w_exc  = bus.exc_valid;
  assign w_irq  = !w_exc & bus.irq_take & w_irq_pending;
  assign w_mret = !w_exc & !w_irq & bus.mret;
  assign w_csr  = !w_exc & !w_irq & !w_mret & bus.csr_we;
  assign w_trap = w_exc | w_irq;

  always_comb begin
    w_irq_cause = MCAUSE_IRQ_MTI;
    if (bus.meip & core_q.meie) begin
      w_irq_cause = MCAUSE_IRQ_MEI;
    end else if (bus.msip & core_q.msie) begin
      w_irq_cause = MCAUSE_IRQ_MSI;
    end
  end

  always_comb begin
    core_d           = core_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (w_trap) begin
      core_d.mepc      = (w_exc ? bus.exc_pc : bus.irq_pc) & c_PC_ALIGN_MASK;
      core_d.mcause    = w_exc ? bus.exc_cause : w_irq_cause;
      core_d.mtval     = w_exc ? bus.exc_tval : 32'h0;
      core_d.mpie      = core_q.mie;
      core_d.mie       = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = {core_q.mtvec_base, 2'b00};
    end else if (w_mret) begin
      core_d.mie       = core_q.mpie;
      core_d.mpie      = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = core_q.mepc;
    end else if (w_csr) begin
      core_d = core_of(bus.csr_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_q           <= c_CORE_RST;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      core_q           <= core_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!core_q.mcycle_inhibit),
    .we_i  (w_csr),
    .wd_i  (bus.csr_next.mcycle),
    .q_o   (w_mcycle)
  );

  // A trapping instruction never retires, so it must not count
  counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.instr_retire & !core_q.minstret_inhibit & !w_trap),
    .we_i  (w_csr),
    .wd_i  (bus.csr_next.minstret),
    .q_o   (w_minstret)
  );

  always_comb begin
    bus.csr_state.mie              = core_q.mie;
    bus.csr_state.mpie             = core_q.mpie;
    bus.csr_state.mtie             = core_q.mtie;
    bus.csr_state.msie             = core_q.msie;
    bus.csr_state.meie             = core_q.meie;
    bus.csr_state.mtvec_base       = core_q.mtvec_base;
    bus.csr_state.mcycle           = w_mcycle;
    bus.csr_state.minstret         = w_minstret;
    bus.csr_state.mcycle_inhibit   = core_q.mcycle_inhibit;
    bus.csr_state.minstret_inhibit = core_q.minstret_inhibit;
    bus.csr_state.mscratch         = core_q.mscratch;
    bus.csr_state.mepc             = core_q.mepc;
    bus.csr_state.mcause           = core_q.mcause;
    bus.csr_state.mtval            = core_q.mtval;
  end

  assign bus.irq_pending    = w_irq_pending;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_state_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_csr_state_unit: directed scoreboard bench for csr_state_unit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_csr_state_unit;
  import csr_state_unit_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_state_unit_if bus ();

  csr_state_unit #(.RESET_MTVEC(32'h8000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];
  csr_state_t nx;

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.csr_we       = 1'b0;
    bus.exc_valid    = 1'b0;
    bus.irq_take     = 1'b0;
    bus.mret         = 1'b0;
    bus.instr_retire = 1'b0;
    bus.exc_tval     = 32'h0;
  endtask

  task automatic csr_write();
    bus.csr_next = nx;
    bus.csr_we   = 1'b1;
    step();
    bus.csr_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    nx = '0;
    bus.csr_next = '0;
    bus.mtip = 1'b0; bus.msip = 1'b0; bus.meip = 1'b0;
    bus.exc_cause = MCAUSE_INSTR_MISALIGN;
    bus.exc_pc = 32'h0; bus.irq_pc = 32'h0;
    clear_events();
    #2 rst_n = 1'b0;
    #1;

    // Reset state
    push("rst_mtvec", 64'h2000_0040); push("rst_mie", 0); push("rst_mcause", 0);
    push("rst_mepc", 0); push("rst_mcycle", 0); push("rst_minstret", 0);
    push("rst_rv", 0); push("rst_rpc", 0); push("rst_pend", 0);
    chk(bus.csr_state.mtvec_base); chk(bus.csr_state.mie); chk(bus.csr_state.mcause);
    chk(bus.csr_state.mepc); chk(bus.csr_state.mcycle); chk(bus.csr_state.minstret);
    chk(bus.redirect_valid); chk(bus.redirect_pc); chk(bus.irq_pending);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable mie through a CSR write
    nx.mtvec_base = 30'h2000_0040; nx.mie = 1'b1;
    nx.mscratch = 32'h1234_5678; nx.mcycle = 64'd100;
    push("wr_mie", 1); push("wr_mscratch", 64'h1234_5678); push("wr_mcycle", 100);
    csr_write();
    chk(bus.csr_state.mie); chk(bus.csr_state.mscratch); chk(bus.csr_state.mcycle);

    // Synchronous exception; the trapping instruction does not count as retired
    bus.exc_valid = 1'b1; bus.exc_cause = MCAUSE_ILLEGAL_INSTR;
    bus.exc_pc = 32'h100; bus.exc_tval = 32'hDEAD; bus.instr_retire = 1'b1;
    push("exc_mepc", 64'h100); push("exc_mcause", 2); push("exc_mtval", 64'hDEAD);
    push("exc_mie", 0); push("exc_mpie", 1); push("exc_minstret", 0);
    push("exc_rv", 1); push("exc_rpc", 64'h8000_0100); push("exc_mcycle", 101);
    step();
    clear_events();
    chk(bus.csr_state.mepc); chk(bus.csr_state.mcause); chk(bus.csr_state.mtval);
    chk(bus.csr_state.mie); chk(bus.csr_state.mpie); chk(bus.csr_state.minstret);
    chk(bus.redirect_valid); chk(bus.redirect_pc); chk(bus.csr_state.mcycle);
    push("exc_rv_pulse_end", 0);
    step();
    chk(bus.redirect_valid);

    // Interrupt entry with all sources pending: MEI wins
    nx.mie = 1'b1; nx.meie = 1'b1; nx.msie = 1'b1; nx.mtie = 1'b1;
    push("irq_pend_none", 0);
    csr_write();
    chk(bus.irq_pending);
    bus.meip = 1'b1; bus.msip = 1'b1; bus.mtip = 1'b1;
    #1;
    push("irq_pend_all", 1);
    chk(bus.irq_pending);
    bus.irq_take = 1'b1; bus.irq_pc = 32'h204; bus.exc_tval = 32'hFFFF;
    push("mei_mcause", 64'h8000_000B); push("mei_mepc", 64'h204); push("mei_mtval", 0);
    push("mei_mie", 0); push("mei_mpie", 1); push("mei_rv", 1);
    push("mei_rpc", 64'h8000_0100); push("mei_pend", 0);
    step();
    clear_events();
    chk(bus.csr_state.mcause); chk(bus.csr_state.mepc); chk(bus.csr_state.mtval);
    chk(bus.csr_state.mie); chk(bus.csr_state.mpie); chk(bus.redirect_valid);
    chk(bus.redirect_pc); chk(bus.irq_pending);

    // mret restores mie and redirects to the saved mepc
    bus.mret = 1'b1;
    push("mret_mie", 1); push("mret_mpie", 1); push("mret_rv", 1);
    push("mret_rpc", 64'h204); push("mret_mcause", 64'h8000_000B);
    step();
    clear_events();
    chk(bus.csr_state.mie); chk(bus.csr_state.mpie); chk(bus.redirect_valid);
    chk(bus.redirect_pc); chk(bus.csr_state.mcause);

    // MSI beats MTI; mepc is word aligned
    bus.meip = 1'b0; bus.irq_take = 1'b1; bus.irq_pc = 32'h30A;
    push("msi_mcause", 64'h8000_0003); push("msi_mepc", 64'h308);
    step();
    clear_events();
    chk(bus.csr_state.mcause); chk(bus.csr_state.mepc);

    // irq_take with mie=0 is ignored, so the concurrent mret commits
    bus.irq_take = 1'b1; bus.mret = 1'b1; bus.irq_pc = 32'h700;
    push("ign_mie", 1); push("ign_mcause", 64'h8000_0003);
    push("ign_rv", 1); push("ign_rpc", 64'h308);
    step();
    clear_events();
    chk(bus.csr_state.mie); chk(bus.csr_state.mcause);
    chk(bus.redirect_valid); chk(bus.redirect_pc);

    // Only MTI left
    bus.msip = 1'b0; bus.irq_take = 1'b1; bus.irq_pc = 32'h400;
    push("mti_mcause", 64'h8000_0007);
    step();
    clear_events();
    bus.mtip = 1'b0;
    chk(bus.csr_state.mcause);

    // mcycle wrap and write-wins
    nx.mie = 1'b0; nx.mcycle = '1;
    push("mcyc_max", 64'hFFFF_FFFF_FFFF_FFFF);
    csr_write();
    chk(bus.csr_state.mcycle);
    push("mcyc_wrap", 0);
    step();
    chk(bus.csr_state.mcycle);
    nx.mcycle = 64'd5; nx.minstret = 64'd7; bus.instr_retire = 1'b1;
    push("mcyc_wr", 5); push("minst_wr", 7);
    csr_write();
    chk(bus.csr_state.mcycle); chk(bus.csr_state.minstret);
    push("mcyc_inc", 6); push("minst_inc", 8);
    step();
    chk(bus.csr_state.mcycle); chk(bus.csr_state.minstret);
    nx.minstret = '1;
    push("minst_max", 64'hFFFF_FFFF_FFFF_FFFF);
    csr_write();
    chk(bus.csr_state.minstret);
    push("minst_wrap", 0);
    step();
    chk(bus.csr_state.minstret);

    // Inhibited counters hold
    nx.mcycle_inhibit = 1'b1; nx.minstret_inhibit = 1'b1;
    nx.mcycle = 64'd10; nx.minstret = 64'd20;
    csr_write();
    push("inh_mcyc", 10); push("inh_minst", 20);
    step();
    chk(bus.csr_state.mcycle); chk(bus.csr_state.minstret);
    bus.instr_retire = 1'b0;
    nx.mcycle_inhibit = 1'b0; nx.minstret_inhibit = 1'b0; nx.mie = 1'b1;
    csr_write();

    // Exception + mret + csr_we together: only the trap commits
    bus.exc_valid = 1'b1; bus.exc_cause = MCAUSE_ECALL_M; bus.exc_pc = 32'h500;
    bus.mret = 1'b1;
    nx.mscratch = 32'h0000_BEEF;
    bus.csr_next = nx;
    bus.csr_we = 1'b1;
    push("pri_mscratch", 64'h1234_5678); push("pri_mcause", 64'hB); push("pri_mepc", 64'h500);
    push("pri_rv", 1); push("pri_rpc", 64'h8000_0100); push("pri_mie", 0); push("pri_mpie", 1);
    step();
    clear_events();
    chk(bus.csr_state.mscratch); chk(bus.csr_state.mcause); chk(bus.csr_state.mepc);
    chk(bus.redirect_valid); chk(bus.redirect_pc); chk(bus.csr_state.mie);
    chk(bus.csr_state.mpie);

    // Reset while the redirect pulse is live
    bus.exc_valid = 1'b1; bus.exc_cause = MCAUSE_BREAKPOINT; bus.exc_pc = 32'h600;
    push("rt_rv_before", 1);
    step();
    clear_events();
    chk(bus.redirect_valid);
    rst_n = 1'b0;
    #1;
    push("rt_rv", 0); push("rt_rpc", 0); push("rt_mepc", 0); push("rt_mcause", 0);
    push("rt_mtvec", 64'h2000_0040); push("rt_mcycle", 0); push("rt_mscratch", 0);
    chk(bus.redirect_valid); chk(bus.redirect_pc); chk(bus.csr_state.mepc);
    chk(bus.csr_state.mcause); chk(bus.csr_state.mtvec_base); chk(bus.csr_state.mcycle);
    chk(bus.csr_state.mscratch);
    @(negedge clk);
    rst_n = 1'b1;

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
